uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// UART command front end: decodes received bytes into game commands, drops
// repeats of the same direction inside a hold window, and queues them in a FWFT FIFO.
module uart_cmd_ctrl #(
    parameter int unsigned REPEAT_GAP = 1_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_done,
    input  logic [7:0]                    rx_byte,
    input  logic                          cmd_ready,
    input  logic                          clr_ovf,
    output logic                          cmd_valid,
    output logic [1:0]                    cmd_dir,
    output logic                          cmd_restart,
    output logic                          overflow,
    output logic [7:0]                    bad_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          dbg_filt_state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(REPEAT_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REPEAT_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        F_OPEN = 1'b0,
        F_HOLD = 1'b1
    } filt_state_e;

    // Handshake: a head entry transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; cmd_valid never depends on cmd_ready.

    // ---------------------------------------------------------------- decode
    logic       dec_rec;
    logic [2:0] dec_code;

    always_comb begin
        dec_rec  = 1'b1;
        dec_code = 3'b000;
        case (rx_byte)
            8'h57, 8'h77: dec_code = 3'b000;
            8'h53, 8'h73: dec_code = 3'b001;
            8'h41, 8'h61: dec_code = 3'b010;
            8'h44, 8'h64: dec_code = 3'b011;
            8'h52, 8'h72: dec_code = 3'b100;
            default:      dec_rec  = 1'b0;
        endcase
    end

    // --------------------------------------------------------- repeat filter
    filt_state_e      state_q, state_d;
    logic [2:0]       last_code_q, last_code_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             cand;

    always_comb begin
        state_d     = state_q;
        last_code_d = last_code_q;
        gap_d       = gap_q;
        cand        = 1'b0;

        if (state_q == F_HOLD) begin
            if (gap_q == GAP_LAST) begin
                state_d = F_OPEN;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end

        // Restart always goes through and never disturbs the hold window.
        if (rx_done && dec_rec) begin
            if (dec_code[2]) begin
                cand = 1'b1;
            end else if (state_q == F_OPEN || dec_code != last_code_q) begin
                cand        = 1'b1;
                last_code_d = dec_code;
                gap_d       = '0;
                state_d     = F_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= F_OPEN;
            last_code_q <= 3'b000;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_code_q <= last_code_d;
            gap_q       <= gap_d;
        end
    end

    assign dbg_filt_state_o = state_q;

    // ------------------------------------------------------------------ FIFO
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [2:0]       head;

    assign full = (count_q == CNT_FULL);
    assign pop  = cmd_valid && cmd_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_code;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign cmd_valid   = (count_q != '0);
    assign cmd_dir     = (cmd_valid && !head[2]) ? head[1:0] : 2'b00;
    assign cmd_restart = cmd_valid && head[2];
    assign fifo_count  = count_q;

    // ------------------------------------------------------ status counters
    logic       ovf_q, ovf_d;
    logic [7:0] bad_q, bad_d;
    logic       bad_evt;

    assign bad_evt = rx_done && !dec_rec;

    // Set events take priority over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        bad_d = bad_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (bad_evt) begin
            bad_d = (bad_q == 8'hFF) ? bad_q : bad_q + 8'd1;
        end else if (clr_ovf) begin
            bad_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            bad_q <= 8'h00;
        end else begin
            ovf_q <= ovf_d;
            bad_q <= bad_d;
        end
    end

    assign overflow = ovf_q;
    assign bad_cnt  = bad_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl (REPEAT_GAP=10, FIFO_DEPTH=4); inputs change
// and outputs are sampled on the falling clock edge.
module tb_uart_cmd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       cmd_ready;
    logic       clr_ovf;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_restart;
    logic       overflow;
    logic [7:0] bad_cnt;
    logic [2:0] fifo_count;
    logic       dbg_filt_state;

    int errors = 0;
    int checks = 0;

    uart_cmd_ctrl #(
        .REPEAT_GAP(10),
        .FIFO_DEPTH(4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_done          (rx_done),
        .rx_byte          (rx_byte),
        .cmd_ready        (cmd_ready),
        .clr_ovf          (clr_ovf),
        .cmd_valid        (cmd_valid),
        .cmd_dir          (cmd_dir),
        .cmd_restart      (cmd_restart),
        .overflow         (overflow),
        .bad_cnt          (bad_cnt),
        .fifo_count       (fifo_count),
        .dbg_filt_state_o (dbg_filt_state)
    );

    // ------------------------------------------------------ clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        rx_done   = 1'b0;
        cmd_ready = 1'b0;
        clr_ovf   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------------------------------------------------- driver tasks
    // All drivers start and end on a falling edge.
    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    // ------------------------------------------------------------- scenarios
    task automatic test_reset();
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", cmd_valid); end
        checks++; if (cmd_dir !== 2'd0) begin errors++; $display("FAIL rst_dir got=%0d exp=0", cmd_dir); end
        checks++; if (cmd_restart !== 1'b0) begin errors++; $display("FAIL rst_restart got=%0b exp=0", cmd_restart); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%0b exp=0", overflow); end
        checks++; if (bad_cnt !== 8'd0) begin errors++; $display("FAIL rst_bad got=%0d exp=0", bad_cnt); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_cmd();
        do_reset();
        send(8'h77);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", cmd_valid); end
        checks++; if (cmd_dir !== 2'd0) begin errors++; $display("FAIL single_dir got=%0d exp=0", cmd_dir); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
        pop_one();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%0b exp=0", cmd_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", fifo_count); end
        pop_one();
        pop_one();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL empty_ready_count got=%0d exp=0", fifo_count); end
        // Push while cmd_ready is already high on an empty FIFO.
        cmd_ready = 1'b1;
        send(8'h73);
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL empty_pushpop_valid got=%0b exp=1", cmd_valid); end
        checks++; if (cmd_dir !== 2'd1) begin errors++; $display("FAIL empty_pushpop_dir got=%0d exp=1", cmd_dir); end
    endtask

    task automatic test_decode();
        logic [7:0] set_a [4];
        logic [7:0] set_b [4];
        set_a = '{8'h57, 8'h73, 8'h41, 8'h64};
        set_b = '{8'h77, 8'h53, 8'h61, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) send(set_a[i]);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL dec_a_count got=%0d exp=4", fifo_count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_dir !== 2'(i) || cmd_restart !== 1'b0) begin errors++; $display("FAIL dec_a_dir%0d got=%0d/%0b exp=%0d/0", i, cmd_dir, cmd_restart, i); end
            pop_one();
        end
        for (int i = 0; i < 4; i++) send(set_b[i]);
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_dir !== 2'(i) || cmd_restart !== 1'b0) begin errors++; $display("FAIL dec_b_dir%0d got=%0d/%0b exp=%0d/0", i, cmd_dir, cmd_restart, i); end
            pop_one();
        end
        send(8'h72);
        checks++; if (cmd_restart !== 1'b1 || cmd_dir !== 2'd0) begin errors++; $display("FAIL dec_restart got=%0b/%0d exp=1/0", cmd_restart, cmd_dir); end
        pop_one();
        send(8'h58);
        checks++; if (fifo_count !== 3'd0 || bad_cnt !== 8'd1) begin errors++; $display("FAIL dec_bad got=%0d/%0d exp=0/1", fifo_count, bad_cnt); end
    endtask

    task automatic test_repeat_gap();
        logic [1:0] exp_dir [3];
        do_reset();
        rx_byte = 8'h64;
        for (int c = 0; c <= 12; c++) begin
            if (c == 6) begin
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL gap_discard_count got=%0d exp=1", fifo_count); end
            end
            rx_done = (c == 0 || c == 5 || c == 12);
            @(negedge clk);
        end
        rx_done = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL gap_count got=%0d exp=2", fifo_count); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (cmd_dir !== 2'd3) begin errors++; $display("FAIL gap_dir%0d got=%0d exp=3", i, cmd_dir); end
            pop_one();
        end
        do_reset();
        exp_dir = '{2'd2, 2'd3, 2'd2};
        send(8'h61);
        @(negedge clk);
        send(8'h64);
        @(negedge clk);
        send(8'h61);
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL alt_count got=%0d exp=3", fifo_count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cmd_dir !== exp_dir[i]) begin errors++; $display("FAIL alt_dir%0d got=%0d exp=%0d", i, cmd_dir, exp_dir[i]); end
            pop_one();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Restart bypasses the filter, so the following 'W' is still a repeat.
        send(8'h57);
        send(8'h52);
        send(8'h57);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", fifo_count); end
        checks++; if (cmd_dir !== 2'd0 || cmd_restart !== 1'b0) begin errors++; $display("FAIL b2b_head0 got=%0d/%0b exp=0/0", cmd_dir, cmd_restart); end
        pop_one();
        checks++; if (cmd_restart !== 1'b1 || cmd_dir !== 2'd0) begin errors++; $display("FAIL b2b_head1 got=%0b/%0d exp=1/0", cmd_restart, cmd_dir); end
        pop_one();
        checks++; if (cmd_valid !== 1'b0 || cmd_restart !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%0b/%0b exp=0/0", cmd_valid, cmd_restart); end
    endtask

    task automatic test_overflow();
        do_reset();
        send(8'h57);
        send(8'h53);
        send(8'h41);
        send(8'h44);
        send(8'h52);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        checks++; if (cmd_dir !== 2'd0) begin errors++; $display("FAIL ovf_head got=%0d exp=0", cmd_dir); end
        clr_ovf = 1'b1;
        send(8'h77);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%0b exp=1", overflow); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [1:0] exp_dir [4];
        logic       exp_rst [4];
        exp_dir = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_rst = '{1'b0, 1'b0, 1'b0, 1'b1};
        // Continues from the full FIFO left by test_overflow.
        cmd_ready = 1'b1;
        send(8'h52);
        cmd_ready = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fullpp_count got=%0d exp=4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%0b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_dir !== exp_dir[i] || cmd_restart !== exp_rst[i]) begin errors++; $display("FAIL fullpp_head%0d got=%0d/%0b exp=%0d/%0b", i, cmd_dir, cmd_restart, exp_dir[i], exp_rst[i]); end
            pop_one();
        end
        checks++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL fullpp_drain got=%0b/%0d exp=0/0", cmd_valid, fifo_count); end
    endtask

    task automatic test_bad_cnt();
        do_reset();
        rx_byte = 8'h58;
        rx_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bad_cnt !== 8'd3) begin errors++; $display("FAIL bad_three got=%0d exp=3", bad_cnt); end
        clr_ovf = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        checks++; if (bad_cnt !== 8'd4) begin errors++; $display("FAIL bad_set_wins got=%0d exp=4", bad_cnt); end
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (bad_cnt !== 8'd0) begin errors++; $display("FAIL bad_clear got=%0d exp=0", bad_cnt); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL bad_no_push got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        send(8'h57);
        send(8'h53);
        send(8'h41);
        send(8'h44);
        send(8'h52);
        rx_byte = 8'h00;
        rx_done = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (bad_cnt !== 8'd255) begin errors++; $display("FAIL sat_bad got=%0d exp=255", bad_cnt); end
        checks++; if (overflow !== 1'b1 || fifo_count !== 3'd4) begin errors++; $display("FAIL sat_state got=%0b/%0d exp=1/4", overflow, fifo_count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0 || cmd_dir !== 2'd0 || cmd_restart !== 1'b0) begin errors++; $display("FAIL midrst_cmd got=%0b/%0d/%0b exp=0/0/0", cmd_valid, cmd_dir, cmd_restart); end
        checks++; if (overflow !== 1'b0 || bad_cnt !== 8'd0 || fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_status got=%0b/%0d/%0d exp=0/0/0", overflow, bad_cnt, fifo_count); end
        checks++; if (dbg_filt_state !== 1'b0) begin errors++; $display("FAIL midrst_filt got=%0b exp=0", dbg_filt_state); end
        @(negedge clk);
        rx_done = 1'b0;
        rst_n   = 1'b1;
        send(8'h77);
        checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd0 || fifo_count !== 3'd1) begin errors++; $display("FAIL post_rst_push got=%0b/%0d/%0d exp=1/0/1", cmd_valid, cmd_dir, fifo_count); end
        send(8'h77);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL post_rst_repeat got=%0d exp=1", fifo_count); end
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        rst_n     = 1'b0;
        rx_done   = 1'b0;
        rx_byte   = 8'h00;
        cmd_ready = 1'b0;
        clr_ovf   = 1'b0;
        test_reset();
        test_single_cmd();
        test_decode();
        test_repeat_gap();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_bad_cnt();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
